uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//  Sequences the UART receive path at power-up: takes IMAGE_BYTES bytes from the UART receiver,
//  packs them little-endian into 32-bit words and writes them into CPU instruction memory.
//  Holds the CPU in reset until the image is loaded, then releases it.
//  Sits between the UART RX byte stage and the cpu core's instruction RAM write port.
// PARAMETERS
//  IMAGE_BYTES     112        image length in bytes (1..4*2**ADDR_W)
//  ADDR_W          8          instruction-memory word-address width
//  BASE_ADDR       0          first word address written
//  TIMEOUT_CYCLES  1_000_000  max idle clk cycles between bytes once loading (10 ms @100 MHz)
// PORTS
//  clk           in   1       system clock (100 MHz)
//  rst_n         in   1       asynchronous active-low reset
//  rx_valid      in   1       1-cycle strobe: rx_data holds a received byte
//  rx_data       in   8       received byte
//  rx_frame_err  in   1       1-cycle strobe: stop bit was 0 on current frame
//  reload        in   1       sync request: return to IDLE from DONE/ERROR
//  mem_we        out  1       1-cycle instruction-RAM write strobe
//  mem_addr      out  ADDR_W  word address for mem_we
//  mem_wdata     out  32      word data for mem_we
//  cpu_rst_n     out  1       CPU reset, low until load completes
//  boot_done     out  1       image loaded (sticky)
//  boot_err      out  1       load aborted (sticky)
// BEHAVIOUR
//  Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst_n=0, boot_done=0, boot_err=0;
//   byte counter, word buffer, timeout counter = 0; state=IDLE. Reset mid-load discards all progress.
//  States: IDLE -> LOAD on first rx_valid; LOAD -> DONE after byte IMAGE_BYTES (or CHECK if macro);
//   LOAD -> ERROR on rx_frame_err or timeout; DONE/ERROR -> IDLE on reload (clears done/err, cpu_rst_n=0).
//  Byte k (0-based) lands in word bits [8*(k%4)+:8]. On the byte completing a word (k%4==3) or on
//   the last image byte, mem_we pulses exactly 1 cycle later with the packed word; unfilled bytes of
//   a partial final word are 0. mem_addr = BASE_ADDR + k/4, wraps modulo 2**ADDR_W.
//  A new rx_valid in the same cycle as mem_we is accepted (packing and write are independent).
//  rx_frame_err in IDLE is ignored; in LOAD it wins over a simultaneous rx_valid (byte dropped).
//  Timeout counter clears on every rx_valid, counts only in LOAD; reaching TIMEOUT_CYCLES -> ERROR.
//  DONE: cpu_rst_n=1 and boot_done=1 from the cycle after the last mem_we; rx_valid ignored.
//  ERROR: boot_err=1, cpu_rst_n=0, no further mem_we; rx_valid ignored.
//  reload in IDLE/LOAD is ignored. cpu_rst_n is a registered output (glitch-free).
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: after the image, one extra byte is expected (CHECK state, timeout applies);
//   8-bit sum of all image bytes plus that byte must be 0x00 -> DONE, else ERROR. Checksum byte not written.
//  BOOT_CHECKSUM_EN undefined: no CHECK state; LOAD -> DONE directly after the last image byte.
// STRUCTURE
//  Shared header boot_pkg.vh: state encodings (IDLE, LOAD, CHECK, DONE, ERROR), WORD_BYTES=4.
//  One sub-module: boot_word_packer (byte lane steering, partial-word flush, mem_we/addr generation);
//   top holds FSM, byte counter, timeout counter, checksum accumulator.
// TESTING
//  1. 112 bytes 0x00..0x6F, 1 idle cycle between strobes -> 28 writes, addr 0..27, word0=0x03020100,
//     word27=0x6F6E6D6C; boot_done=1, cpu_rst_n=1 one cycle after last mem_we.
//  2. IMAGE_BYTES=6, bytes 11 22 33 44 55 66 -> writes 0x44332211 @0, 0x00006655 @1, then DONE.
//  3. rx_frame_err on byte 10 -> boot_err=1, cpu_rst_n=0, only 2 mem_we seen; reload -> IDLE, reload again OK.
//  4. TIMEOUT_CYCLES=50, stop after 5 bytes -> ERROR exactly 50 cycles after last rx_valid; 1 mem_we only.
//  5. BOOT_CHECKSUM_EN, sum 0x00 -> DONE; corrupt checksum byte -> ERROR, cpu_rst_n stays 0.
//  6. rst_n low mid-load (byte 40) -> all outputs at reset values; fresh 112-byte load then succeeds.

Source files
------------

// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader.
//   boot_state_e : loader FSM states (CHECK is only reachable when the
//                  BOOT_CHECKSUM_EN macro is defined)
//   WORD_BYTES   : bytes packed into one instruction word
//   cnt_width()  : width of the image byte counter (at least 2 bits so the
//                  low two bits always give the byte lane)
package uart_boot_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } boot_state_e;

  function automatic int cnt_width(input int image_bytes);
    return ($clog2(image_bytes) < 2) ? 2 : $clog2(image_bytes);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Byte-to-word packer for the boot loader.
// Steers each accepted byte into its little-endian lane of a 32-bit word and
// emits a one-cycle write strobe the cycle after the byte that completes a
// word (lane 3) or the last image byte (partial word, upper lanes zero).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous return to the start-of-image state
//   byte_valid   accept byte_data this cycle
//   byte_data    byte to pack
//   byte_lane    lane (0..3) the byte lands in
//   byte_last    byte is the final image byte (forces a flush)
//   mem_we       1-cycle instruction-RAM write strobe
//   mem_addr     word address for mem_we (BASE_ADDR + word index, wraps)
//   mem_wdata    packed word for mem_we
module boot_word_packer #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic [1:0]        byte_lane,
  input  logic              byte_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]       word_buf;
  logic [31:0]       word_next;
  logic [ADDR_W-1:0] word_addr;
  logic              flush;

  always_comb begin
    // Lane 0 starts a fresh word, so stale bytes never leak into a partial
    // final word.
    word_next = (byte_lane == 2'd0) ? '0 : word_buf;
    word_next[{byte_lane, 3'b000} +: 8] = byte_data;
    flush = byte_valid && ((byte_lane == 2'd3) || byte_last);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_buf  <= '0;
      word_addr <= BASE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
    end else if (clear) begin
      word_buf  <= '0;
      word_addr <= BASE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
    end else begin
      mem_we <= flush;
      if (byte_valid) word_buf <= word_next;
      if (flush) begin
        mem_addr  <= word_addr;
        mem_wdata <= word_next;
        word_addr <= word_addr + 1'b1;  // wraps modulo 2**ADDR_W
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives IMAGE_BYTES bytes from the UART RX byte stage,
// packs them little-endian into 32-bit words written to CPU instruction RAM,
// and holds the CPU in reset until the image is complete.
// Optional feature macro: BOOT_CHECKSUM_EN -- expect one extra byte after the
// image; the 8-bit sum of all image bytes plus that byte must be zero.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   rx_valid       1-cycle strobe, rx_data holds a received byte
//   rx_data        received byte
//   rx_frame_err   1-cycle strobe, framing error on the current frame
//   reload         return to IDLE from DONE/ERROR
//   mem_we         1-cycle instruction-RAM write strobe
//   mem_addr       word address for mem_we
//   mem_wdata      word data for mem_we
//   cpu_rst_n      registered CPU reset, high only once the load completed
//   boot_done      image loaded (sticky until reload)
//   boot_err       load aborted (sticky until reload)
module uart_boot_loader #(
  parameter int          IMAGE_BYTES    = 112,
  parameter int          ADDR_W         = 8,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_err,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              boot_err
);

  import uart_boot_loader_pkg::*;

  localparam int CNT_W = cnt_width(IMAGE_BYTES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMAGE_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e AFTER_IMAGE = ST_CHECK;
`else
  localparam boot_state_e AFTER_IMAGE = ST_DONE;
`endif

  boot_state_e      state;
  boot_state_e      state_next;
  logic [CNT_W-1:0] byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             byte_accept;
  logic             byte_last;
  logic             tmo_hit;
  logic             loading;
  logic             pack_clear;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       sum;
  logic [7:0]       sum_next;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_next  = state;
    byte_accept = 1'b0;
    pack_clear  = 1'b0;
    byte_last   = (byte_cnt == LAST_IDX);
    tmo_hit     = (tmo_cnt == TMO_LAST);
    loading     = (state == ST_LOAD) || (state == ST_CHECK);
`ifdef BOOT_CHECKSUM_EN
    sum_next    = sum + rx_data;
`endif
    case (state)
      // A framing error before the first byte is line noise, not a failed load.
      ST_IDLE: begin
        if (rx_valid) begin
          byte_accept = 1'b1;
          state_next  = byte_last ? AFTER_IMAGE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (rx_frame_err) begin
          state_next = ST_ERROR;  // the coincident byte is dropped
        end else if (rx_valid) begin
          byte_accept = 1'b1;
          if (byte_last) state_next = AFTER_IMAGE;
        end else if (tmo_hit) begin
          state_next = ST_ERROR;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_frame_err) begin
          state_next = ST_ERROR;
        end else if (rx_valid) begin
          state_next = (sum_next == 8'h00) ? ST_DONE : ST_ERROR;
        end else if (tmo_hit) begin
          state_next = ST_ERROR;
        end
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_next = ST_IDLE;
          pack_clear = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (pack_clear) begin
      byte_cnt <= '0;
    end else if (byte_accept) begin
      byte_cnt <= byte_last ? '0 : byte_cnt + 1'b1;
    end
  end

  // Idle-gap watchdog: restarts on every byte, runs only while a load is in
  // progress, so IDLE can wait indefinitely for the first byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (rx_valid || !loading) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (pack_clear) begin
      sum <= '0;
    end else if (byte_accept) begin
      sum <= sum_next;
    end
  end
`endif

  // Status outputs are registered so cpu_rst_n never glitches. DONE flags
  // rise one cycle after entering DONE, i.e. the cycle after the last write,
  // and drop in the same edge that a reload leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n <= 1'b0;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      cpu_rst_n <= (state == ST_DONE) && (state_next == ST_DONE);
      boot_done <= (state == ST_DONE) && (state_next == ST_DONE);
      boot_err  <= (state_next == ST_ERROR);
    end
  end

  boot_word_packer #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pack_clear),
    .byte_valid(byte_accept),
    .byte_data (rx_data),
    .byte_lane (byte_cnt[1:0]),
    .byte_last (byte_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed testbench for uart_boot_loader.
// dut_a: default parameters (112-byte image). dut_b: 6-byte image with a
// 50-cycle inter-byte timeout. Inputs change #1 after a rising edge; write
// strobes and flag edges are captured on the falling edge.
module tb_uart_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a signals
  logic        a_rst_n, a_rx_valid, a_rx_frame_err, a_reload;
  logic [7:0]  a_rx_data;
  logic        a_mem_we, a_cpu_rst_n, a_boot_done, a_boot_err;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  // dut_b signals
  logic        b_rst_n, b_rx_valid, b_rx_frame_err, b_reload;
  logic [7:0]  b_rx_data;
  logic        b_mem_we, b_cpu_rst_n, b_boot_done, b_boot_err;
  logic [7:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;

  uart_boot_loader dut_a (
    .clk(clk), .rst_n(a_rst_n), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
    .rx_frame_err(a_rx_frame_err), .reload(a_reload), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .cpu_rst_n(a_cpu_rst_n),
    .boot_done(a_boot_done), .boot_err(a_boot_err)
  );

  uart_boot_loader #(.IMAGE_BYTES(6), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .rx_frame_err(b_rx_frame_err), .reload(b_reload), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .cpu_rst_n(b_cpu_rst_n),
    .boot_done(b_boot_done), .boot_err(b_boot_err)
  );

  // Write/flag monitors (cumulative; tests take a base snapshot).
  int          a_we_cnt = 0, b_we_cnt = 0;
  logic [31:0] a_words [256];
  logic [7:0]  a_addrs [256];
  logic [31:0] b_words [256];
  int          a_last_we_cyc = 0, a_done_cyc = 0, b_rv_cyc = 0, b_err_cyc = 0;
  logic        a_done_prev = 1'b0, b_err_prev = 1'b0;

  always @(negedge clk) begin
    if (a_mem_we) begin
      a_words[a_we_cnt[7:0]] = a_mem_wdata;
      a_addrs[a_we_cnt[7:0]] = a_mem_addr;
      a_last_we_cyc = cyc;
      a_we_cnt++;
    end
    if (a_boot_done && !a_done_prev) a_done_cyc = cyc;
    a_done_prev = a_boot_done;
    if (b_mem_we) begin
      b_words[b_we_cnt[7:0]] = b_mem_wdata;
      b_we_cnt++;
    end
    if (b_rx_valid) b_rv_cyc = cyc;
    if (b_boot_err && !b_err_prev) b_err_cyc = cyc;
    b_err_prev = b_boot_err;
  end

  int checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte for one cycle, then hold the line idle for gap cycles.
  task automatic send(input bit sel, input logic [7:0] d, input bit ferr, input int gap);
    if (sel) begin b_rx_valid = 1'b1; b_rx_data = d; b_rx_frame_err = ferr; end
    else     begin a_rx_valid = 1'b1; a_rx_data = d; a_rx_frame_err = ferr; end
    step(1);
    if (sel) begin b_rx_valid = 1'b0; b_rx_frame_err = 1'b0; end
    else     begin a_rx_valid = 1'b0; a_rx_frame_err = 1'b0; end
    step(gap);
  endtask

  task automatic pulse_reload(input bit sel);
    if (sel) b_reload = 1'b1; else a_reload = 1'b1;
    step(1);
    if (sel) b_reload = 1'b0; else a_reload = 1'b0;
    step(2);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, " mem_we"},    32'(a_mem_we),    32'd0);
    check({tag, " mem_addr"},  32'(a_mem_addr),  32'd0);
    check({tag, " mem_wdata"}, a_mem_wdata,      32'd0);
    check({tag, " cpu_rst_n"}, 32'(a_cpu_rst_n), 32'd0);
    check({tag, " boot_done"}, 32'(a_boot_done), 32'd0);
    check({tag, " boot_err"},  32'(a_boot_err),  32'd0);
  endtask

  // Full 112-byte image 0x00..0x6F on dut_a; every word is {4i+3,4i+2,4i+1,4i}.
  task automatic full_load_a(input string tag);
    int base;
    logic [31:0] exp;
    base = a_we_cnt;
    for (int i = 0; i < 112; i++) send(1'b0, 8'(i), 1'b0, 1);
    step(4);
    check({tag, " write count"}, 32'(a_we_cnt - base), 32'd28);
    for (int i = 0; i < 28; i++) begin
      exp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      check($sformatf("%s word%0d", tag, i), a_words[8'(base+i)], exp);
      check($sformatf("%s addr%0d", tag, i), 32'(a_addrs[8'(base+i)]), 32'(i));
    end
    check({tag, " done 1 cycle after last write"}, 32'(a_done_cyc - a_last_we_cyc), 32'd1);
    check({tag, " boot_done"}, 32'(a_boot_done), 32'd1);
    check({tag, " cpu_rst_n"}, 32'(a_cpu_rst_n), 32'd1);
    check({tag, " boot_err"},  32'(a_boot_err),  32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  int base;

  initial begin
    a_rst_n = 1'b0; a_rx_valid = 1'b0; a_rx_data = '0; a_rx_frame_err = 1'b0; a_reload = 1'b0;
    b_rst_n = 1'b0; b_rx_valid = 1'b0; b_rx_data = '0; b_rx_frame_err = 1'b0; b_reload = 1'b0;
    step(3);
    check_a_reset("reset");
    check("reset b cpu_rst_n", 32'(b_cpu_rst_n), 32'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    step(2);

    // Framing error and reload in IDLE are ignored.
    a_rx_frame_err = 1'b1;
    step(1);
    a_rx_frame_err = 1'b0;
    pulse_reload(1'b0);
    check("idle ferr boot_err", 32'(a_boot_err), 32'd0);
    check("idle ferr writes",   32'(a_we_cnt),   32'd0);

    // Frame error on byte 10: words 0 and 1 written, then ERROR.
    base = a_we_cnt;
    for (int i = 0; i < 10; i++) send(1'b0, 8'(i), 1'b0, 1);
    send(1'b0, 8'd10, 1'b1, 1);
    step(3);
    check("ferr boot_err",  32'(a_boot_err),  32'd1);
    check("ferr cpu_rst_n", 32'(a_cpu_rst_n), 32'd0);
    check("ferr boot_done", 32'(a_boot_done), 32'd0);
    check("ferr writes",    32'(a_we_cnt - base), 32'd2);
    check("ferr word0", a_words[8'(base)],   32'h03020100);
    check("ferr word1", a_words[8'(base+1)], 32'h07060504);
    send(1'b0, 8'h55, 1'b0, 3);
    check("error ignores rx writes", 32'(a_we_cnt - base), 32'd2);
    pulse_reload(1'b0);
    check("reload clears boot_err", 32'(a_boot_err), 32'd0);
    pulse_reload(1'b0);
    check("second reload boot_err", 32'(a_boot_err), 32'd0);

    // Full image after recovering from the error.
    full_load_a("full");
    base = a_we_cnt;
    send(1'b0, 8'hAA, 1'b0, 3);
    check("done ignores rx writes", 32'(a_we_cnt - base), 32'd0);
    check("done ignores rx done",   32'(a_boot_done),     32'd1);

    // Reset in the middle of a load, then a fresh full load.
    pulse_reload(1'b0);
    check("reload drops cpu_rst_n", 32'(a_cpu_rst_n), 32'd0);
    check("reload drops boot_done", 32'(a_boot_done), 32'd0);
    for (int i = 0; i < 40; i++) send(1'b0, 8'(i), 1'b0, 1);
    a_rst_n = 1'b0;
    #2;
    check_a_reset("midload reset");
    step(2);
    a_rst_n = 1'b1;
    step(2);
    full_load_a("after reset");

    // dut_b: 6-byte image, bytes back-to-back so byte 4 coincides with the
    // first write strobe.
    base = b_we_cnt;
    send(1'b1, 8'h11, 1'b0, 0);
    send(1'b1, 8'h22, 1'b0, 0);
    send(1'b1, 8'h33, 1'b0, 0);
    send(1'b1, 8'h44, 1'b0, 0);
    send(1'b1, 8'h55, 1'b0, 0);
    send(1'b1, 8'h66, 1'b0, 0);
`ifdef BOOT_CHECKSUM_EN
    send(1'b1, 8'h9B, 1'b0, 0);  // 0x11+..+0x66 = 0x165 -> 0x65; 0x65+0x9B = 0x100
`endif
    step(4);
    check("short writes", 32'(b_we_cnt - base), 32'd2);
    check("short word0",  b_words[8'(base)],   32'h44332211);
    check("short word1",  b_words[8'(base+1)], 32'h00006655);
    check("short boot_done", 32'(b_boot_done), 32'd1);
    check("short cpu_rst_n", 32'(b_cpu_rst_n), 32'd1);

    // Timeout: 5 of 6 bytes, then silence.
    pulse_reload(1'b1);
    base = b_we_cnt;
    for (int i = 1; i <= 5; i++) send(1'b1, 8'(i), 1'b0, 1);
    step(60);
    check("timeout boot_err",  32'(b_boot_err),  32'd1);
    check("timeout cpu_rst_n", 32'(b_cpu_rst_n), 32'd0);
    check("timeout writes",    32'(b_we_cnt - base), 32'd1);
    // Strobe seen in cycle n is sampled by the next edge; the error is
    // registered 50 edges after that, so observed one cycle later still.
    check("timeout latency", 32'(b_err_cyc - b_rv_cyc), 32'd51);

`ifdef BOOT_CHECKSUM_EN
    pulse_reload(1'b1);
    send(1'b1, 8'h11, 1'b0, 1);
    send(1'b1, 8'h22, 1'b0, 1);
    send(1'b1, 8'h33, 1'b0, 1);
    send(1'b1, 8'h44, 1'b0, 1);
    send(1'b1, 8'h55, 1'b0, 1);
    send(1'b1, 8'h66, 1'b0, 1);
    send(1'b1, 8'h9C, 1'b0, 3);
    check("bad checksum boot_err",  32'(b_boot_err),  32'd1);
    check("bad checksum cpu_rst_n", 32'(b_cpu_rst_n), 32'd0);
    check("bad checksum boot_done", 32'(b_boot_done), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
